// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Brief    : N-channel to 1 memory request arbiter with in-order response
//            routing. Optional macro ARB_ROUND_ROBIN_EN selects round-robin
//            grant; default build uses fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int OT_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_wr,
    input  logic [2*NUM_CH-1:0]      ch_size,
    input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
    input  logic [4*NUM_CH-1:0]      ch_wstrb,
    input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_addr_ok,
    output logic [NUM_CH-1:0]        ch_data_ok,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     m_req,
    output logic                     m_wr,
    output logic [1:0]               m_size,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [3:0]               m_wstrb,
    output logic [DATA_W-1:0]        m_wdata,
    input  logic                     m_addr_ok,
    input  logic                     m_data_ok,
    input  logic [DATA_W-1:0]        m_rdata,
    output logic                     err_unexp
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(OT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(OT_DEPTH);

    logic [CH_W-1:0]  w_arb;
    logic [CH_W-1:0]  w_grant;
    logic [CH_W-1:0]  w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_pop;

    logic             r_locked;
    logic [CH_W-1:0]  r_lock_ch;
    logic [CH_W-1:0]  r_fifo [OT_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [CH_W:0]   C_NUM  = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W-1:0] C_LAST = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]     r_rr_ptr;
    logic [2*NUM_CH-1:0] w_dbl;
    logic [NUM_CH-1:0]   w_rot;
    logic [CH_W:0]       w_sum;
    logic                w_found;

    // Rotate requests so bit 0 is the channel at rr_ptr; first set bit wins.
    always_comb begin
        w_dbl   = {ch_req, ch_req};
        w_rot   = NUM_CH'(w_dbl >> r_rr_ptr);
        w_arb   = r_rr_ptr;
        w_sum   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (CH_W + 1)'(k);
                if (w_sum >= C_NUM) begin
                    w_sum = w_sum - C_NUM;
                end
                w_arb = CH_W'(w_sum);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_grant == C_LAST) ? '0 : w_grant + 1'b1;
        end
    end
`else
    always_comb begin
        w_arb = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_req[k]) begin
                w_arb = CH_W'(k);
            end
        end
    end
`endif

    // A pending, unaccepted request keeps its channel until accepted.
    assign w_grant  = r_locked ? r_lock_ch : w_arb;
    assign w_full   = (r_count == C_FULL);
    assign w_empty  = (r_count == '0);
    assign m_req    = (|ch_req) && !w_full;
    assign w_accept = m_req && m_addr_ok;
    assign w_pop    = m_data_ok && !w_empty;
    assign w_head   = r_fifo[r_rd_ptr];
    assign ch_rdata = m_rdata;
    assign err_unexp = r_err;

    always_comb begin
        m_wr       = 1'b0;
        m_size     = '0;
        m_addr     = '0;
        m_wstrb    = '0;
        m_wdata    = '0;
        ch_addr_ok = '0;
        ch_data_ok = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_grant == CH_W'(k)) begin
                m_wr          = ch_wr[k];
                m_size        = ch_size[2*k +: 2];
                m_addr        = ch_addr[ADDR_W*k +: ADDR_W];
                m_wstrb       = ch_wstrb[4*k +: 4];
                m_wdata       = ch_wdata[DATA_W*k +: DATA_W];
                ch_addr_ok[k] = w_accept;
            end
            if (w_head == CH_W'(k)) begin
                ch_data_ok[k] = w_pop;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_locked  <= 1'b0;
            r_lock_ch <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_locked  <= m_req && !m_addr_ok;
            r_lock_ch <= w_grant;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (m_data_ok && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= w_grant;
        end
    end

endmodule
`default_nettype wire
